// File: rtl/scaling_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the scaling config register block.
// The master drives requests and accepts responses; the slave does the opposite.
interface scaling_axil_regs_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/scaling_axil_regs.sv
// AXI4-Lite slave holding the scaling block's four 32-bit config registers plus write pulses.
// Define SCALING_AXIL_SLVERR_EN to answer unmapped addresses with SLVERR instead of OKAY.
module scaling_axil_regs #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL          = '0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    scaling_axil_regs_if.slave                s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   cfg_regs,
    output logic [3:0]                        cfg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SCALING_AXIL_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t       r_wstate, w_wstate_next;
    rstate_t       r_rstate, w_rstate_next;
    logic          r_rdy_en;
    logic          r_aw_done, r_w_done;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic [1:0]    r_bresp, r_rresp;
    logic [DW-1:0] r_rdata;
    logic [3:0]    r_wr_pulse;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic          w_wr_mapped, w_rd_mapped;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic [SW-1:0] w_wr_strb;
    logic [1:0]    w_wr_idx, w_rd_idx;
    logic [DW-1:0] w_regs [4];
    logic          w_unused;

    // READY stays low until the first edge after reset release
    assign s_axi.S_AXI_AWREADY = r_rdy_en & (r_wstate == W_IDLE) & ~r_aw_done;
    assign s_axi.S_AXI_WREADY  = r_rdy_en & (r_wstate == W_IDLE) & ~r_w_done;
    assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_rdy_en & (r_rstate == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign cfg_wr_pulse        = r_wr_pulse;

    assign w_aw_hs = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_w_hs  = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign w_ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;

    // Commit uses whichever of address/data is arriving this cycle, else the latched copy
    assign w_commit    = (r_wstate == W_IDLE) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_wr_addr   = w_aw_hs ? s_axi.S_AXI_AWADDR : r_awaddr;
    assign w_wr_data   = w_w_hs ? s_axi.S_AXI_WDATA : r_wdata;
    assign w_wr_strb   = w_w_hs ? s_axi.S_AXI_WSTRB : r_wstrb;
    assign w_wr_mapped = (w_wr_addr[AW-1:4] == '0);
    assign w_wr_idx    = w_wr_addr[3:2];
    assign w_rd_mapped = (s_axi.S_AXI_ARADDR[AW-1:4] == '0);
    assign w_rd_idx    = s_axi.S_AXI_ARADDR[3:2];

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        w_wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_next = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
                if (w_wr_mapped && (|w_wr_strb))
                    r_wr_pulse[w_wr_idx] <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                    r_awaddr  <= s_axi.S_AXI_AWADDR;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                    r_wdata  <= s_axi.S_AXI_WDATA;
                    r_wstrb  <= s_axi.S_AXI_WSTRB;
                end
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic [DW-1:0] r_reg;

        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                r_reg <= RESET_VAL;
            end else if (w_commit && w_wr_mapped && (w_wr_idx == 2'(gi))) begin
                for (int b = 0; b < SW; b++)
                    if (w_wr_strb[b]) r_reg[8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end

        assign w_regs[gi]             = r_reg;
        assign cfg_regs[gi*DW +: DW]  = r_reg;
    end

    // Read data is captured from the registers before any same-edge write lands
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_mapped ? w_regs[w_rd_idx] : '0;
            r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
        end
    end
endmodule
